// File: rtl/return_addr_stack_if.sv
// rtl/return_addr_stack_if.sv - Call/return request and counter-redirect bundle for the return-address stack
interface return_addr_stack_if #(
  parameter int AW = 26,
  parameter int PW = 3
);
  // Requests from the fetch/decode side
  logic          call;
  logic          ret;
  logic [AW-1:0] ret_addr_in;
  logic          flush;
  logic          clr_flags;

  // Redirect pair toward the program counter's load interface
  logic          load;
  logic [AW-1:0] load_val;

  // Status
  logic [AW-1:0] top_addr;
  logic [PW:0]   depth;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  // Requester side: issues call/ret, observes redirect and status
  modport master (
    output call, ret, ret_addr_in, flush, clr_flags,
    input  load, load_val, top_addr, depth, empty, full, overflow, underflow
  );

  // Stack side
  modport slave (
    input  call, ret, ret_addr_in, flush, clr_flags,
    output load, load_val, top_addr, depth, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - Circular return-address stack driving the program counter's load/load_val redirect
module return_addr_stack #(
  parameter int AW    = 26,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  return_addr_stack_if.slave   bus
);

  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  // Storage and registered state
  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tp;
  logic [PW:0]   cnt;
  logic          load_r;
  logic [AW-1:0] load_val_r;
  logic          ovf_r;
  logic          unf_r;

  // Decoded per-cycle events
  logic          is_empty;
  logic          is_full;
  logic          pop_ok;
  logic          replace;
  logic          push;
  logic          ovf_set;
  logic          unf_set;
  logic [PW-1:0] tp_nxt;
  logic [PW:0]   cnt_nxt;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);

  // Classify this cycle's request; flush suppresses call and ret entirely.
  // A ret on a non-empty stack pops; if a call arrives with it the pushed
  // address simply replaces the popped top, so tp and depth stay put.
  // A ret on an empty stack only flags underflow and lets any call proceed.
  always_comb begin
    pop_ok  = 1'b0;
    replace = 1'b0;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    tp_nxt  = tp;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_idx  = tp;
    if (bus.flush) begin
      cnt_nxt = '0;
    end else begin
      if (bus.ret && !is_empty) begin
        pop_ok = 1'b1;
        if (bus.call) begin
          replace = 1'b1;
          wr_en   = 1'b1;
          wr_idx  = tp;
        end else begin
          tp_nxt  = tp - 1'b1;
          cnt_nxt = cnt - 1'b1;
        end
      end else begin
        unf_set = bus.ret;
        if (bus.call) begin
          push    = 1'b1;
          tp_nxt  = tp + 1'b1;
          wr_en   = 1'b1;
          wr_idx  = tp + 1'b1;
          if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
    end
  end

  // Pointer, depth, redirect pulse and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      tp         <= '0;
      cnt        <= '0;
      load_r     <= 1'b0;
      load_val_r <= '0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
    end else begin
      tp     <= tp_nxt;
      cnt    <= cnt_nxt;
      load_r <= pop_ok;
      if (pop_ok) begin
        load_val_r <= mem[tp];
      end
      ovf_r <= (ovf_r && !bus.clr_flags) || ovf_set;
      unf_r <= (unf_r && !bus.clr_flags) || unf_set;
    end
  end

  // Entry storage; contents need no reset since depth gates every read
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_idx] <= bus.ret_addr_in;
    end
  end

  assign bus.load      = load_r;
  assign bus.load_val  = load_val_r;
  assign bus.top_addr  = is_empty ? '0 : mem[tp];
  assign bus.depth     = cnt;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - Directed and randomized bench for return_addr_stack against a queue model
module tb_return_addr_stack;

  localparam int AW    = 26;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  return_addr_stack_if #(.AW(AW), .PW(PW)) bus ();

  return_addr_stack #(.AW(AW), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of live entries, oldest at front, top at back
  logic [AW-1:0] mq[$];
  logic          m_load;
  logic [AW-1:0] m_lv;
  logic          m_ovf;
  logic          m_unf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic c, input logic r, input logic [AW-1:0] a,
                            input logic f, input logic cl, input logic rs);
    logic ovf_set;
    logic unf_set;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (rs) begin
      mq.delete();
      m_load = 1'b0;
      m_lv   = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_load = 1'b0;
      if (f) begin
        mq.delete();
      end else if (r && mq.size() > 0) begin
        m_load = 1'b1;
        m_lv   = mq[$];
        if (c) mq[mq.size()-1] = a;
        else   void'(mq.pop_back());
      end else begin
        if (r) unf_set = 1'b1;
        if (c) begin
          mq.push_back(a);
          if (mq.size() > DEPTH) begin
            void'(mq.pop_front());
            ovf_set = 1'b1;
          end
        end
      end
      m_ovf = (m_ovf && !cl) || ovf_set;
      m_unf = (m_unf && !cl) || unf_set;
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] exp_top;
    exp_top = (mq.size() > 0) ? mq[$] : '0;
    check_eq({tag, ".load"},      32'(bus.load),      32'(m_load));
    check_eq({tag, ".load_val"},  32'(bus.load_val),  32'(m_lv));
    check_eq({tag, ".depth"},     32'(bus.depth),     32'(mq.size()));
    check_eq({tag, ".top_addr"},  32'(bus.top_addr),  32'(exp_top));
    check_eq({tag, ".empty"},     32'(bus.empty),     32'(mq.size() == 0));
    check_eq({tag, ".full"},      32'(bus.full),      32'(mq.size() == DEPTH));
    check_eq({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    check_eq({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
  endtask

  // Drive one cycle of inputs, advance the model, then compare just after the edge
  task automatic step(input string tag, input logic c, input logic r, input logic [AW-1:0] a,
                      input logic f, input logic cl, input logic rs);
    bus.call        = c;
    bus.ret         = r;
    bus.ret_addr_in = a;
    bus.flush       = f;
    bus.clr_flags   = cl;
    reset           = rs;
    model_step(c, r, a, f, cl, rs);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.call = 0; bus.ret = 0; bus.ret_addr_in = '0; bus.flush = 0; bus.clr_flags = 0;
    reset = 1'b1;
    mq.delete(); m_load = 0; m_lv = '0; m_ovf = 0; m_unf = 0;

    // Reset state
    step("rst", 0, 0, '0, 0, 0, 1);
    step("rst2", 0, 0, '0, 0, 0, 1);

    // Basic call/call/ret
    step("c10", 1, 0, 26'h10, 0, 0, 0);
    step("c20", 1, 0, 26'h20, 0, 0, 0);
    check_eq("tp1.depth2", 32'(bus.depth), 32'd2);
    step("r1", 0, 1, '0, 0, 0, 0);
    check_eq("tp1.load", 32'(bus.load), 32'd1);
    check_eq("tp1.load_val", 32'(bus.load_val), 32'h20);
    check_eq("tp1.top", 32'(bus.top_addr), 32'h10);
    step("idle1", 0, 0, '0, 0, 0, 0);
    check_eq("tp1.load_drop", 32'(bus.load), 32'd0);
    check_eq("tp1.lv_hold", 32'(bus.load_val), 32'h20);

    // Overflow then drain
    step("rst_b", 0, 0, '0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) step("push9", 1, 0, AW'(i), 0, 0, 0);
    check_eq("tp2.full", 32'(bus.full), 32'd1);
    check_eq("tp2.ovf", 32'(bus.overflow), 32'd1);
    check_eq("tp2.depth", 32'(bus.depth), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step("pop8", 0, 1, '0, 0, 0, 0);
      check_eq("tp2.seq", 32'(bus.load_val), 32'(9 - i));
    end
    check_eq("tp2.empty", 32'(bus.empty), 32'd1);
    step("pop9", 0, 1, '0, 0, 0, 0);
    check_eq("tp2.noload", 32'(bus.load), 32'd0);
    check_eq("tp2.unf", 32'(bus.underflow), 32'd1);

    // Simultaneous call+ret on non-empty stack
    step("rst_c", 0, 0, '0, 0, 0, 1);
    step("c100", 1, 0, 26'h100, 0, 0, 0);
    step("c200", 1, 0, 26'h200, 0, 0, 0);
    step("cr300", 1, 1, 26'h300, 0, 0, 0);
    check_eq("tp3.load", 32'(bus.load), 32'd1);
    check_eq("tp3.lv", 32'(bus.load_val), 32'h200);
    check_eq("tp3.top", 32'(bus.top_addr), 32'h300);
    check_eq("tp3.depth", 32'(bus.depth), 32'd2);

    // Simultaneous call+ret on empty stack
    step("rst_d", 0, 0, '0, 0, 0, 1);
    step("cr_empty", 1, 1, 26'h3FFFFFF, 0, 0, 0);
    check_eq("tp4.load", 32'(bus.load), 32'd0);
    check_eq("tp4.unf", 32'(bus.underflow), 32'd1);
    check_eq("tp4.depth", 32'(bus.depth), 32'd1);
    check_eq("tp4.top", 32'(bus.top_addr), 32'h3FFFFFF);

    // Flush with ret, sticky flags, clr_flags vs same-cycle underflow
    step("c_a", 1, 0, 26'h1234, 0, 0, 0);
    step("c_b", 1, 0, 26'h5678, 0, 0, 0);
    step("flush_ret", 0, 1, '0, 1, 0, 0);
    check_eq("tp5.depth", 32'(bus.depth), 32'd0);
    check_eq("tp5.load", 32'(bus.load), 32'd0);
    check_eq("tp5.unf_kept", 32'(bus.underflow), 32'd1);
    step("clr_ret", 0, 1, '0, 0, 1, 0);
    check_eq("tp5.clr_loses", 32'(bus.underflow), 32'd1);
    step("clr", 0, 0, '0, 0, 1, 0);
    check_eq("tp5.cleared", 32'(bus.underflow), 32'd0);

    // Reset right after a ret cancels the pending redirect
    step("c_x", 1, 0, 26'hAAA, 0, 0, 0);
    step("c_y", 1, 0, 26'hBBB, 0, 0, 0);
    step("r_y", 0, 1, '0, 0, 0, 0);
    step("rst_e", 0, 0, '0, 0, 0, 1);
    check_eq("tp6.load", 32'(bus.load), 32'd0);
    check_eq("tp6.lv", 32'(bus.load_val), 32'd0);
    check_eq("tp6.depth", 32'(bus.depth), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic c, r, f, cl, rs;
      logic [AW-1:0] a;
      c  = ($urandom_range(99) < 45);
      r  = ($urandom_range(99) < 40);
      f  = ($urandom_range(99) < 3);
      cl = ($urandom_range(99) < 5);
      rs = ($urandom_range(999) < 5);
      a  = AW'($urandom);
      step("rand", c, r, a, f, cl, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack. On a call it captures the counter's next-sequential address; on a return it drives the counter's load/load_val redirect pair.
- It sits beside the 26-bit program counter, which increments every cycle unless loaded. This block is the producer of the counter's load interface and the consumer of its count_next output.
- Circular storage: overflow overwrites the oldest entry. Overflow and underflow are reported through sticky flags.

Parameters:
- AW, 26, address width; matches the program counter width.
- DEPTH, 8, number of stack entries; must be a power of two, at least 2.
- PW, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- call  input  1  push request; ret_addr_in is captured this cycle.
- ret  input  1  pop request; redirect is issued next cycle.
- ret_addr_in  input  AW  return address; tied to the counter's count_next.
- flush  input  1  discard all entries (pipeline flush or exception); sticky flags are not cleared.
- clr_flags  input  1  clears overflow and underflow.
- load  output  1  one-cycle redirect pulse to the counter's load input.
- load_val  output  AW  redirect target to the counter's load_val input.
- top_addr  output  AW  current top entry; 0 when empty.
- depth  output  PW+1  number of valid entries, 0..DEPTH.
- empty  output  1  depth == 0.
- full  output  1  depth == DEPTH.
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (synchronous, active-high): top pointer 0, depth 0, load 0, load_val 0, overflow 0, underflow 0. Storage contents are don't-care.
- Reset issued mid-operation: a load scheduled for the next cycle is cancelled.
- Storage is a DEPTH-entry array. Top pointer tp indexes the top entry; tp arithmetic wraps modulo DEPTH.
- Event priority per cycle: reset > flush > call/ret.
- flush:
  - depth becomes 0.
  - A coincident call or ret is ignored, and load is 0 next cycle.
  - overflow and underflow are unchanged.
- call only:
  - tp increments, ret_addr_in is written at the new tp.
  - If not full, depth increments.
  - If full, depth stays DEPTH, the oldest entry is lost, and overflow is set.
- ret only, not empty:
  - Next cycle load=1 and load_val = entry[tp] as sampled this cycle.
  - tp decrements and depth decrements.
- ret only, empty:
  - load stays 0, load_val holds its previous value, underflow is set.
  - tp and depth are unchanged.
- call and ret together:
  - If not empty: next cycle load=1, load_val = old top; entry[tp] is overwritten with ret_addr_in; tp and depth are unchanged.
  - If empty: underflow is set, no load, and the push proceeds as call only (depth 0→1).
- load timing:
  - Registered, asserted exactly one cycle after the accepted ret, high for one cycle only.
  - Back-to-back rets give back-to-back load pulses with successive entries.
- load_val holds its last value when load=0.
- top_addr, empty, full and depth are combinational from registered state and reflect the post-update state the cycle after an event.
- clr_flags clears both sticky flags. A flag-setting event in the same cycle wins and sets the flag.
- Address values pass through unmodified; there is no arithmetic on addresses.

Test Plan:
- After reset, call with ret_addr_in=0x0000010, then 0x0000020, then ret → depth 2→1; load=1 for exactly one cycle, one cycle after ret, with load_val=0x0000020; top_addr=0x0000010.
- With DEPTH=8, push 9 addresses 0x1..0x9 → full=1, overflow=1, depth=8. Then 8 rets → load_val sequence 0x9 down to 0x2; empty=1 at end. A 9th ret → no load, underflow=1.
- Stack holds 0x100, 0x200; call(0x300) and ret in the same cycle → next cycle load=1, load_val=0x200; top_addr=0x300; depth stays 2.
- Empty stack; call(0x3FFFFFF) and ret together → load=0, underflow=1, depth=1, top_addr=0x3FFFFFF.
- 3 entries; flush with ret in the same cycle → depth=0, load=0 next cycle. Sticky flags keep their prior values until clr_flags clears them. clr_flags together with an empty ret leaves underflow=1.
- ret on a 2-entry stack, then reset asserted on the following edge → load=0, load_val=0, depth=0, flags 0.
